// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-side inputs and execute-side outputs of the ID/EX pipeline register
interface id_ex_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      regwrite_decode, memtoreg_decode, memwrite_decode;
    logic                      alusrc_decode, regdst_decode, branch_decode;
    logic [1:0]                branch_condition;
    logic [3:0]                alucontrol_decode;
    logic [DATA_WIDTH-1:0]     rd1_decode, rd2_decode, signimm_decode, pcplus4_decode;
    logic [REG_ADDR_WIDTH-1:0] rs_decode, rt_decode, rd_decode, shamt_decode;

    logic                      regwrite_execute, memtoreg_execute, memwrite_execute;
    logic                      alusrc_execute, regdst_execute, branch_execute;
    logic [1:0]                branch_condition_execute;
    logic [3:0]                alucontrol_execute;
    logic [DATA_WIDTH-1:0]     rd1_execute, rd2_execute, signimm_execute, pcplus4_execute;
    logic [REG_ADDR_WIDTH-1:0] rs_execute, rt_execute, rd_execute, shamt_execute;

    modport master (
        output regwrite_decode, memtoreg_decode, memwrite_decode, alusrc_decode, regdst_decode,
               branch_decode, branch_condition, alucontrol_decode, rd1_decode, rd2_decode,
               signimm_decode, pcplus4_decode, rs_decode, rt_decode, rd_decode, shamt_decode,
        input  regwrite_execute, memtoreg_execute, memwrite_execute, alusrc_execute, regdst_execute,
               branch_execute, branch_condition_execute, alucontrol_execute, rd1_execute, rd2_execute,
               signimm_execute, pcplus4_execute, rs_execute, rt_execute, rd_execute, shamt_execute
    );

    modport slave (
        input  regwrite_decode, memtoreg_decode, memwrite_decode, alusrc_decode, regdst_decode,
               branch_decode, branch_condition, alucontrol_decode, rd1_decode, rd2_decode,
               signimm_decode, pcplus4_decode, rs_decode, rt_decode, rd_decode, shamt_decode,
        output regwrite_execute, memtoreg_execute, memwrite_execute, alusrc_execute, regdst_execute,
               branch_execute, branch_condition_execute, alucontrol_execute, rd1_execute, rd2_execute,
               signimm_execute, pcplus4_execute, rs_execute, rt_execute, rd_execute, shamt_execute
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard stall, flush, hold and bubble counter
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int BUBBLE_CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    id_ex_stage_if.slave            bus,
    input  logic                    flush_execute,
    input  logic                    hold_execute,
    output logic                    stall_fetch,
    output logic                    stall_decode,
    output logic [BUBBLE_CNT_W-1:0] bubble_count
);

    typedef struct packed {
        logic                      regwrite;
        logic                      memtoreg;
        logic                      memwrite;
        logic                      alusrc;
        logic                      regdst;
        logic                      branch;
        logic [1:0]                branch_condition;
        logic [3:0]                alucontrol;
        logic [DATA_WIDTH-1:0]     rd1;
        logic [DATA_WIDTH-1:0]     rd2;
        logic [DATA_WIDTH-1:0]     signimm;
        logic [DATA_WIDTH-1:0]     pcplus4;
        logic [REG_ADDR_WIDTH-1:0] rs;
        logic [REG_ADDR_WIDTH-1:0] rt;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_ADDR_WIDTH-1:0] shamt;
    } bundle_t;

    localparam logic [BUBBLE_CNT_W-1:0] CNT_ONE = 1;

    bundle_t                 dec_b;
    bundle_t                 ex_q;
    logic [BUBBLE_CNT_W-1:0] bubble_count_q;
    logic                    load_use;
    logic                    stall;

    assign dec_b = {bus.regwrite_decode, bus.memtoreg_decode, bus.memwrite_decode,
                    bus.alusrc_decode, bus.regdst_decode, bus.branch_decode,
                    bus.branch_condition, bus.alucontrol_decode,
                    bus.rd1_decode, bus.rd2_decode, bus.signimm_decode, bus.pcplus4_decode,
                    bus.rs_decode, bus.rt_decode, bus.rd_decode, bus.shamt_decode};

    // A load in execute whose destination is read by the instruction sitting in decode.
    assign load_use = ex_q.memtoreg && (ex_q.rt != '0) &&
                      ((ex_q.rt == bus.rs_decode) || (ex_q.rt == bus.rt_decode));

    // Gated with rst_n so a random hold during reset cannot freeze the front end.
    assign stall        = rst_n && (load_use || hold_execute) && !flush_execute;
    assign stall_fetch  = stall;
    assign stall_decode = stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q           <= '0;
            bubble_count_q <= '0;
        end else if (flush_execute) begin
            ex_q <= '0;
        end else if (hold_execute) begin
            ex_q <= ex_q;
        end else if (load_use) begin
            ex_q <= '0;
            if (bubble_count_q != '1) begin
                bubble_count_q <= bubble_count_q + CNT_ONE;
            end
        end else begin
            ex_q <= dec_b;
        end
    end

    assign bubble_count = bubble_count_q;

    assign bus.regwrite_execute         = ex_q.regwrite;
    assign bus.memtoreg_execute         = ex_q.memtoreg;
    assign bus.memwrite_execute         = ex_q.memwrite;
    assign bus.alusrc_execute           = ex_q.alusrc;
    assign bus.regdst_execute           = ex_q.regdst;
    assign bus.branch_execute           = ex_q.branch;
    assign bus.branch_condition_execute = ex_q.branch_condition;
    assign bus.alucontrol_execute       = ex_q.alucontrol;
    assign bus.rd1_execute              = ex_q.rd1;
    assign bus.rd2_execute              = ex_q.rd2;
    assign bus.signimm_execute          = ex_q.signimm;
    assign bus.pcplus4_execute          = ex_q.pcplus4;
    assign bus.rs_execute               = ex_q.rs;
    assign bus.rt_execute               = ex_q.rt;
    assign bus.rd_execute               = ex_q.rd;
    assign bus.shamt_execute            = ex_q.shamt;

endmodule
